// File: rtl/register_array_reader.sv
// Snapshots a parallel register array on start and streams a run of words over valid/ready.
// First word valid 1 cycle after start; out_data/out_idx/out_last hold while out_ready is low.
module register_array_reader #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  localparam int IW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in [0:DEPTH-1],
  input  logic             start,
  input  logic [IW-1:0]    start_idx,
  input  logic [IW:0]      count,
  output logic [WIDTH-1:0] out_data,
  output logic [IW-1:0]    out_idx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

  localparam logic [IW:0] DEPTH_W = (IW+1)'(DEPTH);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] snap [0:DEPTH-1];
  logic [IW-1:0]    ptr;
  logic [IW:0]      rem;
  logic             take;
  logic             accept;

  assign take   = (state == IDLE) && start;
  assign accept = (state == STREAM) && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Outputs decode straight from state so an async reset zeroes them without a clock.
  always_comb begin
    state_nxt = state;
    out_valid = 1'b0;
    out_data  = '0;
    out_idx   = '0;
    out_last  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = (count == '0) ? DONE : STREAM;
      end
      STREAM: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_data  = snap[ptr];
        out_idx   = ptr;
        out_last  = (rem == 1);
        if (out_ready && rem == 1) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) snap[i] <= '0;
      ptr <= '0;
      rem <= '0;
    end else if (take) begin
      snap <= data_in;
      ptr  <= start_idx;
      rem  <= (count > DEPTH_W) ? DEPTH_W : count;
    end else if (accept) begin
      ptr <= ptr + 1'b1;
      rem <= rem - 1'b1;
    end
  end

endmodule

// File: tb/tb_register_array_reader.sv
// Directed bench for register_array_reader: full run, wrap, stalls, isolation, clamp, async reset.
module tb_register_array_reader;

  logic        clk;
  logic        rst;
  logic [31:0] data_in [0:15];
  logic        start;
  logic [3:0]  start_idx;
  logic [4:0]  count;
  logic [31:0] out_data;
  logic [3:0]  out_idx;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        busy;
  logic        done;

  int          n_checks;
  int          n_fail;
  logic [31:0] exp_mem [0:15];

  register_array_reader #(.WIDTH(32), .DEPTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .start     (start),
    .start_idx (start_idx),
    .count     (count),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, expv, $time);
    end
  endtask

  // Issues one start, then follows the run beat by beat against the captured snapshot.
  // pat gives out_ready for the first 8 stream cycles (bit i = cycle i), 1 afterwards.
  task automatic do_run(input int sidx, input int cnt, input logic [7:0] pat, input bit corrupt);
    int n;
    int beats;
    int cyc;
    int eidx;
    n = (cnt > 16) ? 16 : cnt;
    for (int i = 0; i < 16; i++) exp_mem[i] = data_in[i];
    start     = 1'b1;
    start_idx = 4'(sidx);
    count     = 5'(cnt);
    @(posedge clk); #1;
    start = 1'b0;
    if (corrupt) for (int i = 0; i < 16; i++) data_in[i] = 32'hDEAD_BEEF;
    beats = 0;
    cyc   = 0;
    while (beats < n && cyc < 100) begin
      eidx = (sidx + beats) % 16;
      chk("valid", 32'(out_valid), 32'd1);
      chk("busy", 32'(busy), 32'd1);
      chk("done_low", 32'(done), 32'd0);
      chk("idx", 32'(out_idx), 32'(eidx));
      chk("data", out_data, exp_mem[eidx]);
      chk("last", 32'(out_last), 32'(beats == n - 1));
      out_ready = (cyc < 8) ? pat[cyc] : 1'b1;
      if (corrupt && cyc == 1) begin
        start     = 1'b1;
        start_idx = 4'd7;
        count     = 5'd2;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      if (out_ready) beats++;
      cyc++;
    end
    start     = 1'b0;
    out_ready = 1'b1;
    chk("beats", 32'(beats), 32'(n));
    chk("done", 32'(done), 32'd1);
    chk("valid_end", 32'(out_valid), 32'd0);
    chk("data_idle", out_data, 32'd0);
    chk("last_idle", 32'(out_last), 32'd0);
    @(posedge clk); #1;
    chk("done_clr", 32'(done), 32'd0);
    chk("busy_clr", 32'(busy), 32'd0);
    chk("valid_clr", 32'(out_valid), 32'd0);
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    start     = 1'b0;
    start_idx = '0;
    count     = '0;
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) data_in[i] = 32'hA000_0000 + 32'(i);
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_idx", 32'(out_idx), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Full array in order, then a wrapping run.
    do_run(0, 16, 8'hFF, 1'b0);
    for (int i = 0; i < 16; i++) data_in[i] = 32'hB000_0000 + 32'(i * 3);
    do_run(14, 4, 8'hFF, 1'b0);

    // Stalls: ready 1,0,0,1,0,1,1,1.
    for (int i = 0; i < 16; i++) data_in[i] = 32'hC000_0100 + 32'(i);
    do_run(2, 5, 8'b1110_1001, 1'b0);

    // Overwrite after start and a second start while busy.
    for (int i = 0; i < 16; i++) data_in[i] = 32'h1234_0000 + 32'(i << 4);
    do_run(10, 6, 8'hFF, 1'b1);

    // Zero-length run, then a clamped one.
    for (int i = 0; i < 16; i++) data_in[i] = 32'hE000_0000 + 32'(i);
    do_run(4, 0, 8'hFF, 1'b0);
    do_run(5, 20, 8'hFF, 1'b0);

    // Async reset after 3 accepted beats.
    for (int i = 0; i < 16; i++) data_in[i] = 32'hF000_0000 + 32'(i);
    start     = 1'b1;
    start_idx = 4'd3;
    count     = 5'd10;
    out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_idx", 32'(out_idx), 32'd6);
    chk("mid_data", out_data, 32'hF000_0006);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_data", out_data, 32'd0);
    @(posedge clk); #1;
    chk("arst_done_hold", 32'(done), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    do_run(9, 3, 8'hFF, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
